// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and the ALU/Mem data access (data first).
// Define ARB_TIMEOUT_EN to abort BUSY accesses after TimeoutCycles cycles without mem_ready.
module mem_port_arbiter #(
    parameter int unsigned AddrW         = 32,
    parameter int unsigned DataW         = 16,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [AddrW-1:0] if_addr,
    output logic             if_ack,
    output logic [DataW-1:0] if_rdata,
    input  logic             dm_rd,
    input  logic             dm_wr,
    input  logic [15:0]      dm_addr,
    input  logic [DataW-1:0] dm_wdata,
    output logic             dm_ack,
    output logic [DataW-1:0] dm_rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [AddrW-1:0] mem_addr,
    output logic [DataW-1:0] mem_wdata,
    input  logic             mem_ready,
    input  logic [DataW-1:0] mem_rdata,
    output logic             stall_fe,
    output logic             stall_mem,
    output logic             err_timeout
);

    if (TimeoutCycles < 1 || TimeoutCycles > 255) begin : g_bad_timeout
        $error("TimeoutCycles must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DM_BUSY = 2'd1,
        IF_BUSY = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_mem_req, w_mem_req_nxt;
    logic               r_mem_we, w_mem_we_nxt;
    logic [AddrW-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [DataW-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic               r_if_ack, w_if_ack_nxt;
    logic               r_dm_ack, w_dm_ack_nxt;
    logic [DataW-1:0]   r_if_rdata, w_if_rdata_nxt;
    logic [DataW-1:0]   r_dm_rdata, w_dm_rdata_nxt;
    logic               r_err_timeout, w_err_nxt;
    logic               w_dm_any;
    logic               w_timeout;

    assign w_dm_any = dm_rd | dm_wr;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_cnt;

    // Held at zero in IDLE, so every BUSY entry starts from a cleared count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
        end else if (!mem_ready) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign w_timeout = (r_state != IDLE) &&
                       (({1'b0, r_cnt} + 9'd1) >= 9'(TimeoutCycles));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_ack_nxt    = 1'b0;
        w_dm_ack_nxt    = 1'b0;
        w_if_rdata_nxt  = r_if_rdata;
        w_dm_rdata_nxt  = r_dm_rdata;
        w_err_nxt       = r_err_timeout;

        case (r_state)
            IDLE: begin
                if (w_dm_any) begin
                    w_mem_addr_nxt  = {{(AddrW-16){1'b0}}, dm_addr};
                    w_mem_we_nxt    = dm_wr;
                    w_mem_wdata_nxt = dm_wdata;
                    w_mem_req_nxt   = 1'b1;
                    w_state_nxt     = DM_BUSY;
                end else if (if_req) begin
                    w_mem_addr_nxt = if_addr;
                    w_mem_we_nxt   = 1'b0;
                    w_mem_req_nxt  = 1'b1;
                    w_state_nxt    = IF_BUSY;
                end
            end
            DM_BUSY: begin
                // mem_ready on the timeout edge still completes normally.
                if (mem_ready) begin
                    w_mem_req_nxt = 1'b0;
                    w_dm_ack_nxt  = 1'b1;
                    w_state_nxt   = IDLE;
                    if (!r_mem_we) begin
                        w_dm_rdata_nxt = mem_rdata;
                    end
                end else if (w_timeout) begin
                    w_mem_req_nxt  = 1'b0;
                    w_dm_ack_nxt   = 1'b1;
                    w_dm_rdata_nxt = '0;
                    w_err_nxt      = 1'b1;
                    w_state_nxt    = IDLE;
                end
            end
            IF_BUSY: begin
                if (mem_ready) begin
                    w_mem_req_nxt  = 1'b0;
                    w_if_ack_nxt   = 1'b1;
                    w_if_rdata_nxt = mem_rdata;
                    w_state_nxt    = IDLE;
                end else if (w_timeout) begin
                    w_mem_req_nxt  = 1'b0;
                    w_if_ack_nxt   = 1'b1;
                    w_if_rdata_nxt = '0;
                    w_err_nxt      = 1'b1;
                    w_state_nxt    = IDLE;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_if_ack      <= 1'b0;
            r_dm_ack      <= 1'b0;
            r_if_rdata    <= '0;
            r_dm_rdata    <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_mem_req     <= w_mem_req_nxt;
            r_mem_we      <= w_mem_we_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
            r_if_ack      <= w_if_ack_nxt;
            r_dm_ack      <= w_dm_ack_nxt;
            r_if_rdata    <= w_if_rdata_nxt;
            r_dm_rdata    <= w_dm_rdata_nxt;
            r_err_timeout <= w_err_nxt;
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign if_ack      = r_if_ack;
    assign dm_ack      = r_dm_ack;
    assign if_rdata    = r_if_rdata;
    assign dm_rdata    = r_dm_rdata;
    assign err_timeout = r_err_timeout;

    assign stall_mem = w_dm_any & ~r_dm_ack;
    assign stall_fe  = stall_mem | (if_req & ~r_if_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected issues/results queued at drive time, popped on DUT output.
// The timeout scenario is compiled in only when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        dm_rd = 1'b0;
    logic        dm_wr = 1'b0;
    logic [15:0] dm_addr = '0;
    logic [15:0] dm_wdata = '0;
    logic        dm_ack;
    logic [15:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        stall_fe;
    logic        stall_mem;
    logic        err_timeout;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AddrW(32),
        .DataW(16),
        .TimeoutCycles(4)
    ) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall_fe(stall_fe), .stall_mem(stall_mem), .err_timeout(err_timeout)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [15:0] wdata;
    } iss_t;

    iss_t        iss_q[$];
    logic [15:0] if_q[$];
    logic [15:0] dm_q[$];
    logic [15:0] mem_img[logic [31:0]];

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_issue_cyc = 0;
    int          wait_cycles = 0;
    int          busy_cnt = 0;
    bit          hold_ready = 1'b0;
    logic [15:0] tb_dm_rdata = '0;
    logic        prev_req = 1'b0;
    logic        prev_if_ack = 1'b0;
    logic        prev_dm_ack = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] rd_img(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return a[15:0] ^ 16'h5A3C;
    endfunction

    // Memory responder: mem_ready after wait_cycles negedges of an outstanding request.
    always @(negedge clk) begin
        if (!mem_req) begin
            mem_ready = 1'b0;
            busy_cnt  = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
        end else if (!hold_ready) begin
            if (busy_cnt >= wait_cycles) begin
                mem_ready = 1'b1;
                if (mem_we) begin
                    mem_rdata = 16'hDEAD;
                    mem_img[mem_addr] = mem_wdata;
                end else begin
                    mem_rdata = rd_img(mem_addr);
                end
            end else begin
                busy_cnt++;
            end
        end
    end

    always @(posedge clk) begin
        iss_t e;
        cyc++;
        #1;
        if (mem_req && !prev_req) begin
            last_issue_cyc = cyc;
            if (iss_q.size() == 0) begin
                check("issue_unexpected", mem_req, 1'b0);
            end else begin
                e = iss_q.pop_front();
                check("mem_addr", mem_addr, e.addr);
                check("mem_we", mem_we, e.we);
                if (e.we) check("mem_wdata", mem_wdata, e.wdata);
            end
        end
        if (if_ack) begin
            check("if_ack_width", prev_if_ack, 1'b0);
            if (if_q.size() == 0) check("if_ack_unexpected", if_ack, 1'b0);
            else check("if_rdata", if_rdata, if_q.pop_front());
        end
        if (dm_ack) begin
            check("dm_ack_width", prev_dm_ack, 1'b0);
            if (dm_q.size() == 0) check("dm_ack_unexpected", dm_ack, 1'b0);
            else check("dm_rdata", dm_rdata, dm_q.pop_front());
        end
        prev_req    = mem_req;
        prev_if_ack = if_ack;
        prev_dm_ack = dm_ack;
    end

    // Counts samples before the ack: stall_mem high, stall_fe high, mem_req high, total.
    task automatic wait_ack(input bit is_dm, output int sm, output int sf, output int rq,
                            output int n, output bit ok);
        ok = 1'b0; sm = 0; sf = 0; rq = 0; n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (is_dm ? dm_ack : if_ack) begin
                ok = 1'b1;
                break;
            end
            sm += int'(stall_mem);
            sf += int'(stall_fe);
            rq += int'(mem_req);
            n++;
        end
        if (!ok) check(is_dm ? "dm_ack_timeout" : "if_ack_timeout", is_dm ? dm_ack : if_ack, 1'b1);
    endtask

    task automatic push_dm(input bit wr, input logic [15:0] a, input logic [15:0] wd);
        iss_t e;
        e.addr = {16'h0000, a}; e.we = wr; e.wdata = wd;
        iss_q.push_back(e);
        if (!wr) tb_dm_rdata = rd_img(e.addr);
        dm_q.push_back(tb_dm_rdata);
    endtask

    task automatic push_if(input logic [31:0] a);
        iss_t e;
        e.addr = a; e.we = 1'b0; e.wdata = '0;
        iss_q.push_back(e);
        if_q.push_back(rd_img(a));
    endtask

    task automatic dm_access(input bit rd, input bit wr, input logic [15:0] a,
                             input logic [15:0] wd, input int waitc);
        int sm, sf, rq, n;
        bit ok;
        @(negedge clk);
        wait_cycles = waitc;
        push_dm(wr, a, wd);
        dm_rd = rd; dm_wr = wr; dm_addr = a; dm_wdata = wd;
        wait_ack(1'b1, sm, sf, rq, n, ok);
        if (ok) begin
            check("stall_mem_cycles", sm, waitc + 1);
            check("stall_mem_at_ack", stall_mem, 1'b0);
        end
        @(negedge clk);
        dm_rd = 1'b0; dm_wr = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input int waitc);
        int sm, sf, rq, n;
        bit ok;
        @(negedge clk);
        wait_cycles = waitc;
        push_if(a);
        if_req = 1'b1; if_addr = a;
        wait_ack(1'b0, sm, sf, rq, n, ok);
        if (ok) begin
            check("stall_fe_cycles", sf, n);
            check("stall_fe_at_ack", stall_fe, 1'b0);
        end
        @(negedge clk);
        if_req = 1'b0;
    endtask

    initial begin
        int sm, sf, rq, n, ack_cyc;
        bit ok;

        #12;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 16'h0);
        check("rst_if_ack", if_ack, 1'b0);
        check("rst_dm_ack", dm_ack, 1'b0);
        check("rst_if_rdata", if_rdata, 16'h0);
        check("rst_dm_rdata", dm_rdata, 16'h0);
        check("rst_err", err_timeout, 1'b0);
        check("rst_stall_fe", stall_fe, 1'b0);
        check("rst_stall_mem", stall_mem, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        mem_img[32'h0000_0040] = 16'hA5A5;
        fetch(32'h0000_0040, 0);

        // Collision: data wins, fetch follows after one IDLE turnaround.
        @(negedge clk);
        wait_cycles = 0;
        push_dm(1'b0, 16'h0010, 16'h0);
        push_if(32'h0000_0080);
        dm_rd = 1'b1; dm_addr = 16'h0010; if_req = 1'b1; if_addr = 32'h0000_0080;
        wait_ack(1'b1, sm, sf, rq, n, ok);
        check("coll_stall_fe_dm", sf, n);
        check("coll_stall_fe_dmack", stall_fe, 1'b1);
        ack_cyc = cyc;
        @(negedge clk);
        dm_rd = 1'b0;
        wait_ack(1'b0, sm, sf, rq, n, ok);
        check("coll_stall_fe_if", sf, n);
        check("coll_turnaround", last_issue_cyc - ack_cyc, 1);
        @(negedge clk);
        if_req = 1'b0;

        dm_access(1'b0, 1'b1, 16'h00FF, 16'h1234, 3);
        dm_access(1'b1, 1'b0, 16'h00FF, 16'h0000, 1);
        dm_access(1'b1, 1'b1, 16'h0100, 16'hBEEF, 0);
        dm_access(1'b1, 1'b0, 16'h0100, 16'h0000, 2);
        fetch(32'h0001_2345, 2);

        // Data request raised while a fetch is BUSY waits for the fetch to finish.
        @(negedge clk);
        wait_cycles = 2;
        push_if(32'h0000_0090);
        if_req = 1'b1; if_addr = 32'h0000_0090;
        @(posedge clk);
        #1;
        check("busy_req", mem_req, 1'b1);
        @(negedge clk);
        push_dm(1'b0, 16'h0022, 16'h0);
        dm_rd = 1'b1; dm_addr = 16'h0022;
        wait_ack(1'b0, sm, sf, rq, n, ok);
        check("busy_stall_mem", stall_mem, 1'b1);
        @(negedge clk);
        if_req = 1'b0;
        wait_ack(1'b1, sm, sf, rq, n, ok);
        @(negedge clk);
        dm_rd = 1'b0;

`ifdef ARB_TIMEOUT_EN
        @(negedge clk);
        hold_ready = 1'b1;
        begin
            iss_t e;
            e.addr = 32'h0000_0030; e.we = 1'b0; e.wdata = '0;
            iss_q.push_back(e);
            tb_dm_rdata = '0;
            dm_q.push_back(16'h0000);
        end
        dm_rd = 1'b1; dm_addr = 16'h0030;
        wait_ack(1'b1, sm, sf, rq, n, ok);
        check("tmo_req_cycles", rq, 4);
        check("tmo_err", err_timeout, 1'b1);
        @(negedge clk);
        dm_rd = 1'b0;
        hold_ready = 1'b0;
        dm_access(1'b1, 1'b0, 16'h0032, 16'h0000, 0);
        check("tmo_err_sticky", err_timeout, 1'b1);
`endif

        // Asynchronous reset mid-access abandons it without an ack.
        @(negedge clk);
        hold_ready = 1'b1;
        wait_cycles = 0;
        begin
            iss_t e;
            e.addr = 32'h0000_0044; e.we = 1'b0; e.wdata = '0;
            iss_q.push_back(e);
        end
        dm_rd = 1'b1; dm_addr = 16'h0044;
        @(posedge clk);
        #1;
        check("arst_busy_req", mem_req, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_mem_req", mem_req, 1'b0);
        check("arst_mem_we", mem_we, 1'b0);
        check("arst_mem_addr", mem_addr, 32'h0);
        check("arst_dm_ack", dm_ack, 1'b0);
        check("arst_dm_rdata", dm_rdata, 16'h0);
        check("arst_if_rdata", if_rdata, 16'h0);
        check("arst_err", err_timeout, 1'b0);
        tb_dm_rdata = '0;
        @(negedge clk);
        dm_rd = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        hold_ready = 1'b0;
        dm_access(1'b1, 1'b0, 16'h0046, 16'h0000, 0);

        repeat (3) @(negedge clk);
        check("sb_issue_left", iss_q.size(), 0);
        check("sb_if_left", if_q.size(), 0);
        check("sb_dm_left", dm_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared memory port between instruction fetch and the data access held in the ALU/Mem pipeline buffer. It issues one access at a time, returns read data with a one-cycle acknowledge, and drives the stall signals that freeze the front-end buffers and the ALU/Mem buffer while an access is outstanding. Data accesses take priority over fetch. It sits between the pipeline buffers and the memory model, on the posedge clock domain shared with the negedge-clocked buffers.

## Interface
- AddrW, 32, memory address width (fetch PC width)
- DataW, 16, memory data width
- TimeoutCycles, 255, max BUSY cycles before abort (8-bit counter; legal 1..255)

- clk  in  1  system clock; the FSM updates on posedge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_ack
- if_addr  in  AddrW  fetch address (PC)
- if_ack  out  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  out  DataW  fetched word
- dm_rd  in  1  data read, from the ALU/Mem buffer memory-control bits
- dm_wr  in  1  data write, from the ALU/Mem buffer memory-control bits
- dm_addr  in  16  data address (ALU result)
- dm_wdata  in  DataW  store data (buffered read_data1)
- dm_ack  out  1  one-cycle pulse; access complete, dm_rdata valid on reads
- dm_rdata  out  DataW  load data
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write
- mem_addr  out  AddrW  memory address
- mem_wdata  out  DataW  memory write data
- mem_ready  in  1  memory completion, sampled on posedge while BUSY
- mem_rdata  in  DataW  memory read data, valid with mem_ready
- stall_fe  out  1  combinational; holds PC, IF/ID and ID/EX buffer enables low
- stall_mem  out  1  combinational; holds the ALU/Mem buffer enable low
- err_timeout  out  1  sticky memory-timeout flag

## Operation
- States: IDLE, DM_BUSY, IF_BUSY.
- IDLE, on posedge:
  - if dm_rd|dm_wr: latch mem_addr={16'b0,dm_addr}, mem_we=dm_wr, mem_wdata=dm_wdata; set mem_req=1; go to DM_BUSY.
  - else if if_req: latch mem_addr=if_addr, mem_we=0; set mem_req=1; go to IF_BUSY.
  - Both pending: data wins. Fetch holds its request.
- dm_rd and dm_wr both high: write wins; no error is raised.
- BUSY, posedge with mem_ready=1:
  - mem_req<=0.
  - Capture mem_rdata into dm_rdata (DM_BUSY, reads only; writes leave dm_rdata unchanged) or into if_rdata (IF_BUSY).
  - Pulse the matching ack; go to IDLE.
- mem_ready is ignored in IDLE.
- Request inputs are sampled only in IDLE. Changes while BUSY have no effect.
- stall_mem = (dm_rd|dm_wr) & ~dm_ack.
- stall_fe = stall_mem | (if_req & ~if_ack).
- In the ack cycle the buffers advance on the following negedge. The next IDLE posedge therefore sees the new request bits, and a request is never served twice.

## Timing
- Reset (rst=0, asynchronous): state=IDLE; mem_req, mem_we, if_ack and dm_ack are 0; mem_addr, mem_wdata, if_rdata and dm_rdata are 0; err_timeout=0; timeout counter=0.
- Reset mid-access abandons the access: mem_req drops immediately and no ack is issued.
- Latency: request seen at posedge N; mem_req high from N. If mem_ready=1 at N+1, the ack is high in cycle N+1..N+2.
- Minimum 2 cycles per access, plus 1 IDLE turnaround cycle between back-to-back accesses.
- Ack outputs are registered and last exactly one cycle. rdata outputs hold until the next capture.
- The timeout counter clears on BUSY entry and increments each BUSY cycle without mem_ready.

## Configuration
- ARB_TIMEOUT_EN defined:
  - When the counter reaches TimeoutCycles in BUSY, mem_req<=0 and the matching ack pulses with its rdata=0.
  - err_timeout<=1, sticky until reset; the FSM goes to IDLE.
  - mem_ready arriving on the same edge as the timeout completes the access normally; no error is raised.
- ARB_TIMEOUT_EN undefined: no counter. BUSY waits indefinitely and err_timeout is tied 0.

## Test plan
- Fetch only: if_req=1, if_addr=32'h0000_0040, mem_ready one cycle after mem_req, mem_rdata=16'hA5A5 -> mem_addr=32'h40, mem_we=0, if_ack pulses once with if_rdata=16'hA5A5; stall_fe low in the ack cycle.
- Collision: dm_rd=1 with dm_addr=16'h0010 and if_req=1 in the same cycle -> data served first (mem_addr=32'h10); fetch issued after dm_ack plus 1 turnaround; stall_fe high throughout.
- Store: dm_wr=1, dm_addr=16'h00FF, dm_wdata=16'h1234, mem_ready after 3 wait cycles -> mem_we=1, mem_wdata=16'h1234, stall_mem high 4 cycles, dm_ack single pulse, dm_rdata unchanged.
- Async reset while in DM_BUSY: rst=0 mid-access -> mem_req=0 immediately, no dm_ack, all outputs 0; after release, a new dm_rd is served from IDLE.
- ARB_TIMEOUT_EN, TimeoutCycles=4, mem_ready held 0 -> mem_req drops after 4 BUSY cycles, dm_ack pulses with dm_rdata=0, err_timeout=1 and stays 1 until reset.
